// File: rtl/vtx_pkg.sv
// Shared types for the vertex transform path.
//   fp16_t        : raw IEEE half-precision word, never interpreted by the controller
//   vec4_t        : x,y,z,w vertex, lane i = element i
//   mat4_t        : row-major 4x4 matrix, element (r,c) at index r*4+c
//   xform_state_t : sequencer states of vertex_xform_ctrl
package vtx_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [3:0] vec4_t;
    typedef fp16_t [15:0] mat4_t;

    localparam fp16_t FP16_ONE = 16'h3C00;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        COMPUTE,
        HOLD
    } xform_state_t;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag, used to time the shared multiplier latency.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset, clears the count to 0
//   load_i     : load load_val_i this cycle (wins over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement this cycle; saturates at 0
//   zero_o     : count is zero
module lat_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vertex_xform_ctrl.sv
// Sequencer sharing one 4x4 fp16 matmul across a vertex stream.
// Holds the active matrix, issues one vertex at a time, waits the multiplier
// latency, then presents the captured result on a valid/ready port.
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   mat_valid/ready/data  : matrix load handshake (row-major 4x4)
//   vtx_valid/ready/data  : input vertex handshake
//   res_valid/ready/data  : transformed vertex handshake
//   mm_a, mm_b, mm_x      : operands to / result from the matmul instance
//   busy                  : vertex in flight (COMPUTE or HOLD)
//   vtx_count             : delivered results, wraps modulo 2^CNT_W
module vertex_xform_ctrl
    import vtx_pkg::*;
#(
    parameter int unsigned LATENCY = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mat_valid,
    output logic             mat_ready,
    input  mat4_t            mat_data,
    input  logic             vtx_valid,
    output logic             vtx_ready,
    input  vec4_t            vtx_data,
    output logic             res_valid,
    input  logic             res_ready,
    output vec4_t            res_data,
    output mat4_t            mm_a,
    output vec4_t            mm_b,
    input  vec4_t            mm_x,
    output logic             busy,
    output logic [CNT_W-1:0] vtx_count
);

    localparam int unsigned     LatW    = $clog2(LATENCY + 1);
    // Loaded at accept; capture happens on the edge that sees zero, i.e.
    // LATENCY edges after the accept edge.
    localparam logic [LatW-1:0] LatLoad = LatW'(LATENCY - 1);

    xform_state_t     state_q, state_d;
    mat4_t            mm_a_q, mm_a_d;
    vec4_t            mm_b_q, mm_b_d;
    vec4_t            res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] vtx_count_q, vtx_count_d;

    logic cnt_load, cnt_dec, cnt_zero;
    logic mat_load, vtx_accept;

    lat_counter #(
        .WIDTH (LatW)
    ) u_lat_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (cnt_load),
        .load_val_i (LatLoad),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Handshake qualifiers decoded straight from the state register.
    assign mat_ready  = (state_q == IDLE) || (state_q == READY);
    assign vtx_ready  = (state_q == READY) && !mat_valid;
    assign busy       = (state_q == COMPUTE) || (state_q == HOLD);
    assign mat_load   = mat_valid && mat_ready;
    assign vtx_accept = vtx_valid && vtx_ready;

    always_comb begin
        state_d     = state_q;
        mm_a_d      = mm_a_q;
        mm_b_d      = mm_b_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        vtx_count_d = vtx_count_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mat_load) begin
                    mm_a_d  = mat_data;
                    state_d = READY;
                end
            end
            READY: begin
                // vtx_ready already excludes mat_valid, so a matrix always wins.
                if (mat_load) begin
                    mm_a_d = mat_data;
                end else if (vtx_accept) begin
                    mm_b_d   = vtx_data;
                    cnt_load = 1'b1;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cnt_zero) begin
                    res_data_d  = mm_x;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    vtx_count_d = vtx_count_q + CNT_W'(1);
                    state_d     = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            vtx_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mm_a_q      <= mm_a_d;
            mm_b_q      <= mm_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            vtx_count_q <= vtx_count_d;
        end
    end

    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign vtx_count = vtx_count_q;

endmodule
